// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add MULT,
// restoring DIV on magnitudes, sign fix-up in a final cycle, plus MTHI/MTLO moves.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             ifunsigned,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;    // multiply accumulator {upper, multiplier}
  logic [WIDTH-1:0]   mcand_reg;  // multiplicand magnitude or divisor magnitude
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   quot_reg;   // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0]   a_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               is_div_reg;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               last_iter;

  assign a_neg = !ifunsigned && A[WIDTH-1];
  assign b_neg = !ifunsigned && B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
  // Trial subtraction one bit wider than the shifted remainder so the borrow is explicit
  assign div_trial = {rem_reg, quot_reg[WIDTH-1]} - {2'b00, mcand_reg};

  assign prod_fix  = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fix  = neg_q_reg ? -quot_reg : quot_reg;
  assign rem_fix   = neg_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      a_reg       <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      is_div_reg  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              2'b00: begin
                acc_reg    <= {{WIDTH{1'b0}}, b_mag};
                mcand_reg  <= a_mag;
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= 1'b0;
                is_div_reg <= 1'b0;
                cnt_reg    <= '0;
                busy       <= 1'b1;
                state_reg  <= MUL;
              end
              2'b01: begin
                rem_reg    <= '0;
                quot_reg   <= a_mag;
                mcand_reg  <= b_mag;
                a_reg      <= A;
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                is_div_reg <= 1'b1;
                cnt_reg    <= '0;
                busy       <= 1'b1;
                state_reg  <= DIV;
              end
              2'b10:   hi <= A;
              default: lo <= A;
            endcase
          end
        end
        MUL: begin
          acc_reg <= {mul_sum, acc_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) state_reg <= FIX;
        end
        DIV: begin
          if (div_trial[WIDTH+1]) begin
            rem_reg  <= {rem_reg[WIDTH-1:0], quot_reg[WIDTH-1]};
            quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
          end else begin
            rem_reg  <= div_trial[WIDTH:0];
            quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) state_reg <= FIX;
        end
        FIX: begin
          if (!is_div_reg) begin
            {hi, lo} <= prod_fix;
          end else if (mcand_reg == '0) begin
            // Divide by zero: remainder is the untouched dividend, quotient saturates
            hi          <= a_reg;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed-vector bench for muldiv_hilo: table of MULT/DIV cases plus hand-written
// sequences for reset, moves, busy-ignore and back-to-back start.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        ifunsigned;
  logic [31:0] A, B;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ifunsigned(ifunsigned),
    .A(A), .B(B), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge just after the sampling edge.
  task automatic issue(input logic [1:0] o, input logic u, input logic [31:0] a, input logic [31:0] b);
    op = o; ifunsigned = u; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done; checks busy and hi/lo hold on the way.
  task automatic wait_done(input string name, input logic [31:0] ohi, input logic [31:0] olo,
                           input int lat0, output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = lat0;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == 10) begin
        chk({name, " hold_hi"}, hi, ohi);
        chk({name, " hold_lo"}, lo, olo);
      end
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd33);
    chk({name, " busy_during"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ohi, olo;
    int lat;
    logic seen;

    tv[0] = '{2'b00, 1'b0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    tv[1] = '{2'b00, 1'b1, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0};
    tv[2] = '{2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tv[3] = '{2'b00, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tv[4] = '{2'b01, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tv[5] = '{2'b01, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    tv[6] = '{2'b01, 1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    tv[7] = '{2'b01, 1'b0, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    tv[8] = '{2'b01, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tv[9] = '{2'b01, 1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    rst = 1'b1; start = 1'b0; op = 2'b00; ifunsigned = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MTHI then MTLO on consecutive cycles
    issue(2'b10, 1'b0, 32'hAAAA0000, 32'hDEADBEEF);
    chk("mthi hi", hi, 32'hAAAA0000);
    chk("mthi lo", lo, 32'd0);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    issue(2'b11, 1'b0, 32'h00005555, 32'hDEADBEEF);
    chk("mtlo hi", hi, 32'hAAAA0000);
    chk("mtlo lo", lo, 32'h00005555);
    chk("mtlo busy", {31'b0, busy}, 32'd0);
    chk("mtlo done", {31'b0, done}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      ohi = hi; olo = lo;
      issue(tv[i].op, tv[i].uns, tv[i].a, tv[i].b);
      wait_done($sformatf("v%0d", i), ohi, olo, 0, lat);
      chk($sformatf("v%0d hi", i), hi, tv[i].hi);
      chk($sformatf("v%0d lo", i), lo, tv[i].lo);
      chk($sformatf("v%0d dbz", i), {31'b0, div_by_zero}, {31'b0, tv[i].dbz});
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", i), {31'b0, done}, 32'd0);
      chk($sformatf("v%0d dbz_pulse", i), {31'b0, div_by_zero}, 32'd0);
    end

    // start during an active DIV is ignored
    ohi = hi; olo = lo;
    issue(2'b01, 1'b1, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    op = 2'b00; ifunsigned = 1'b1; A = 32'd3; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", ohi, olo, 5, lat);
    chk("ignore hi", hi, 32'd2);
    chk("ignore lo", lo, 32'd14);

    // start in the done cycle is accepted
    ohi = hi; olo = lo;
    issue(2'b00, 1'b1, 32'd3, 32'd4);
    wait_done("b2b", ohi, olo, 0, lat);
    chk("b2b hi", hi, 32'd0);
    chk("b2b lo", lo, 32'd12);

    // asynchronous reset mid-MULT
    @(negedge clk);
    issue(2'b00, 1'b0, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    chk("pre_rst busy", {31'b0, busy}, 32'd1);
    chk("pre_rst lo", lo, 32'd12);
    #2 rst = 1'b1;
    #1;
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("midrst no_done", {31'b0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
